// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential signed divider.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package divider_pkg;

    localparam int DIV_WIDTH = 64;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/divider_if.sv
// Start/clear/done handshake and operand/result bus shared with the multiplier.
// Latency: n/a (wiring only).
// Backpressure: none; results are held until the controller issues op_clear.
interface divider_if import divider_pkg::*; #(parameter int WIDTH = DIV_WIDTH) ();

    logic             op_start;
    logic             op_clear;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             op_done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output op_start, op_clear, dividend, divisor,
        input  op_done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  op_start, op_clear, dividend, divisor,
        output op_done, div_by_zero, quotient, remainder
    );

endinterface

// File: rtl/divider_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Latency: combinational.
// Backpressure: none.
module div_step import divider_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
    input  logic [WIDTH-1:0] rem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] dvs_mag,
    output logic [WIDTH-1:0] new_rem,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    // The partial remainder is always below |divisor| <= 2^(WIDTH-1), so the
    // shifted value fits in WIDTH bits and the low WIDTH bits of the trial
    // subtraction are exact whenever it does not borrow.
    always_comb begin
        shifted = {rem, next_bit};
        q_bit   = (shifted >= {1'b0, dvs_mag});
        new_rem = q_bit ? (shifted[WIDTH-1:0] - dvs_mag) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divider.sv
// Sequential signed divider: restoring division on magnitudes, one bit per cycle.
// Latency: WIDTH+1 edges from accept (1 edge when divisor is zero).
// Backpressure: op_start ignored outside IDLE; results held in DONE until op_clear.
module divider import divider_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
    input  logic      clk,
    input  logic      reset_n,
    divider_if.slave  bus
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem_r;      // partial remainder magnitude
    logic [WIDTH-1:0] dq_r;       // dividend bits shift out the top, quotient bits in the bottom
    logic [WIDTH-1:0] dvs_r;      // |divisor|
    logic             sgn_dvd, sgn_dvs;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo_r, rmd_r;
    logic             dbz_r;

    logic             accept, dvs_zero, last_step;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_mag, q_fin, r_fin;

    assign accept    = (state == IDLE) && bus.op_start && !bus.op_clear;
    assign dvs_zero  = (bus.divisor == '0);
    assign last_step = (cnt == LAST);
    // Magnitudes are unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1) without loss.
    assign dvd_mag   = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign dvs_mag   = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .next_bit (dq_r[WIDTH-1]),
        .dvs_mag  (dvs_r),
        .new_rem  (step_rem),
        .q_bit    (step_q)
    );

    // State register: synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: op_clear overrides any transition, including leaving DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = dvs_zero ? DONE : EXEC;
            EXEC:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (bus.op_clear) state_nxt = IDLE;
    end

    // Outputs: sign-corrected final result from the last step, and the held result bus.
    always_comb begin
        q_mag            = {dq_r[WIDTH-2:0], step_q};
        q_fin            = (sgn_dvd ^ sgn_dvs) ? -q_mag : q_mag;
        r_fin            = sgn_dvd ? -step_rem : step_rem;
        bus.op_done      = (state == DONE);
        bus.div_by_zero  = dbz_r;
        bus.quotient     = quo_r;
        bus.remainder    = rmd_r;
    end

    // Datapath: latch operands on accept, iterate in EXEC, load results only when entering DONE.
    always_ff @(posedge clk) begin
        if (!reset_n || bus.op_clear) begin
            quo_r   <= '0;
            rmd_r   <= '0;
            dbz_r   <= 1'b0;
            cnt     <= '0;
            rem_r   <= '0;
            dq_r    <= '0;
            dvs_r   <= '0;
            sgn_dvd <= 1'b0;
            sgn_dvs <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (dvs_zero) begin
                            quo_r <= '1;
                            rmd_r <= bus.dividend;
                            dbz_r <= 1'b1;
                        end else begin
                            rem_r   <= '0;
                            dq_r    <= dvd_mag;
                            dvs_r   <= dvs_mag;
                            sgn_dvd <= bus.dividend[WIDTH-1];
                            sgn_dvs <= bus.divisor[WIDTH-1];
                            cnt     <= '0;
                        end
                    end
                end
                EXEC: begin
                    rem_r <= step_rem;
                    dq_r  <= q_mag;
                    cnt   <= cnt + 1'b1;
                    if (last_step) begin
                        quo_r <= q_fin;
                        rmd_r <= r_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Randomized and directed scoreboard bench for the signed divider.
// Latency: checks WIDTH+1 edge completion and 1 edge divide-by-zero.
// Backpressure: holds op_start high through DONE to confirm it is ignored.
module tb_divider;

    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    divider_if #(.WIDTH(W)) bus ();
    divider #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: plain signed arithmetic, C-style truncation toward zero.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic signed [W-1:0] sa, sb_;
        sa = a;
        sb_ = b;
        if (sb_ == 0) begin
            e.q = '1; e.r = a; e.z = 1'b1;
        end else if (sa == {1'b1, {(W-1){1'b0}}} && sb_ == -1) begin
            e.q = a; e.r = '0; e.z = 1'b0;
        end else begin
            e.q = sa / sb_; e.r = sa % sb_; e.z = 1'b0;
        end
        return e;
    endfunction

    // Monitor: compare on every rising op_done.
    initial begin
        exp_t e;
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.op_done === 1'b1 && !prev) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    chk("quotient", bus.quotient, e.q);
                    chk("remainder", bus.remainder, e.r);
                    chk("div_by_zero", {63'b0, bus.div_by_zero}, {63'b0, e.z});
                end
            end
            prev = (bus.op_done === 1'b1);
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_done"}, {63'b0, bus.op_done}, '0);
        chk({nm, "_dbz"},  {63'b0, bus.div_by_zero}, '0);
        chk({nm, "_q"},    bus.quotient, '0);
        chk({nm, "_r"},    bus.remainder, '0);
    endtask

    // Wait for op_done after an accept edge already taken; lat counts edges from E0 inclusive.
    task automatic wait_done(input int exp_lat);
        int lat = 1;
        while (bus.op_done !== 1'b1 && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic clear_op();
        @(negedge clk); bus.op_start = 1'b0; bus.op_clear = 1'b1;
        @(posedge clk); #1;
        chk_zero("clear");
        @(negedge clk); bus.op_clear = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e = model(a, b);
        @(negedge clk);
        bus.op_start = 1'b1; bus.dividend = a; bus.divisor = b;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.dividend = {$urandom, $urandom};
        bus.divisor  = {$urandom, $urandom};
        wait_done((b == '0) ? 1 : W + 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", {63'b0, bus.op_done}, 64'd1);
        chk("q_held", bus.quotient, e.q);
        clear_op();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] a, b;
        bus.op_start = 1'b0; bus.op_clear = 1'b0;
        bus.dividend = '0;   bus.divisor = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk); reset_n = 1'b1;

        run_op(64'd100, 64'd7);
        run_op(-64'sd19, 64'd10);
        #30;
        run_op(64'd1100, -64'sd10);
        run_op(64'd5, 64'd0);
        run_op(64'h8000_0000_0000_0000, '1);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1_000_000_000_000_000_000);

        // Abort mid-EXEC with op_clear at the 20th EXEC edge.
        @(negedge clk); bus.op_start = 1'b1; bus.dividend = 64'd100; bus.divisor = 64'd3;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk); bus.op_clear = 1'b1; bus.op_start = 1'b0;
        @(posedge clk); #1;
        chk_zero("mid_clear");
        @(negedge clk); bus.op_clear = 1'b0;
        run_op(64'd7, 64'd7);

        // Reset mid-EXEC while op_start stays high, then re-accept on release.
        a = -64'sd12345; b = 64'd77;
        @(negedge clk); bus.op_start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk); reset_n = 1'b0;
        @(posedge clk); #1;
        chk_zero("mid_reset");
        @(negedge clk); reset_n = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk); #1;
        wait_done(W + 1);
        clear_op();

        // Randomized operands across several magnitude classes.
        for (int i = 0; i < 24; i++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       b = {$urandom, $urandom};
                1:       b = 64'($urandom_range(1, 1000));
                default: b = {{32{1'b0}}, 32'($urandom)};
            endcase
            if ($urandom_range(0, 1) == 1) b = -b;
            if (i % 8 == 3) b = '0;
            if (i % 8 == 5) a = 64'($urandom_range(0, 50));
            run_op(a, b);
        end

        repeat (4) @(posedge clk);
        chk("sb_leftover", 64'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider.md
# divider

Sequential signed integer divider, the inverse companion of the team's 64-bit radix-multiplier datapath. It shares the multiplier's start/clear/done handshake so both blocks sit side by side under the same controller. It computes a quotient and a remainder one bit per cycle using restoring division on magnitudes, then applies sign correction.

## Interface
- WIDTH, 64, operand, quotient and remainder width in bits (≥ 2)
- clk  input  1  rising-edge clock, the only clock
- reset_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk
- op_start  input  1  level request to start; sampled only in IDLE
- op_clear  input  1  return to IDLE and clear outputs; higher priority than op_start
- dividend  input  WIDTH  signed two's-complement dividend; sampled on the accept edge only
- divisor  input  WIDTH  signed two's-complement divisor; sampled on the accept edge only
- op_done  output  1  result valid; held until op_clear or reset
- div_by_zero  output  1  set together with op_done when the divisor was 0
- quotient  output  WIDTH  signed quotient, truncated toward zero
- remainder  output  WIDTH  signed remainder; takes the sign of the dividend

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - If op_start=1 and op_clear=0 and divisor≠0: latch |dividend| and |divisor|, the two sign bits, partial remainder=0 and count=0, then go to EXEC.
  - If divisor=0: go directly to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
- EXEC, each cycle:
  - Form trial = {rem[WIDTH-2:0], q_msb} − |divisor| at WIDTH+1 bits.
  - If the trial is non-negative, rem=trial and shift in quotient bit 1; otherwise keep the shifted rem and shift in 0.
  - count increments each cycle. When count=WIDTH−1, go to DONE and load the sign-corrected results.
- Sign correction:
  - quotient is negated when sign(dividend) XOR sign(divisor).
  - remainder is negated when sign(dividend)=1.
- Overflow case: −2^(WIDTH−1) / −1 gives quotient=−2^(WIDTH−1) (wraps) and remainder=0, with no flag.
  - The magnitude of −2^(WIDTH−1) is the unsigned value 2^(WIDTH−1); internal magnitudes are unsigned WIDTH-bit.
- DONE: op_done=1 and the outputs are held stable. op_start is ignored. Only op_clear leaves DONE.
- op_clear=1 in any state: on the next edge the block goes to IDLE and op_done, div_by_zero, quotient, remainder and count are all cleared to 0.
- op_start held high after completion does not restart the block until op_clear has returned it to IDLE.

## Timing
- Reset: the edge with reset_n=0 forces state=IDLE and sets op_done=0, div_by_zero=0, quotient=0, remainder=0. This applies from any state, including mid-EXEC; the in-flight operation is discarded.
- Accept edge E0, when op_start is seen in IDLE:
  - Normal operation: EXEC occupies edges E1..E64 (WIDTH edges). op_done rises after E64, i.e. a latency of WIDTH+1 edges from E0.
  - Divide by zero: op_done and div_by_zero rise after E0, a latency of 1 edge.
- quotient and remainder change only on the edge that enters DONE, or on the edge of a clear or reset. They never show partial values.
- Simultaneous events: reset_n=0 overrides op_clear, which overrides op_start.
- Operand inputs may change freely after E0.

## Structure
- Shared package `divider_pkg`:
  - State encoding constants: IDLE=2'b00, EXEC=2'b01, DONE=2'b10.
  - Default WIDTH.
  - The count width, clog2(WIDTH).
- Sub-module `div_step`: combinational single-iteration restoring step.
  - Inputs: rem, next dividend bit, |divisor|.
  - Outputs: new rem, quotient bit.
- The top level holds the FSM, the counter, the shift registers and sign correction.

## Test plan
- 100 / 7 → quotient=14, remainder=2, div_by_zero=0. op_done rises exactly 65 edges after the accept edge.
- −19 / 10 → quotient=−1, remainder=−9. Then 1100 / −10 → quotient=−110, remainder=0, run after an op_clear with a 30 ns gap.
- 5 / 0 → op_done and div_by_zero high after 1 edge, quotient=all ones, remainder=5.
- −2^63 / −1 → quotient=0x8000_0000_0000_0000, remainder=0, no flag. Also (2^63−1) / 10^18 → quotient=9, remainder=223372036854775807.
- op_clear asserted at the 20th EXEC edge → IDLE next edge with all outputs 0. A following 7 / 7 must give quotient=1, remainder=0 with full latency.
- reset_n=0 for one edge mid-EXEC while op_start stays high → IDLE with outputs 0. The block re-accepts on the next edge and completes correctly.
